// File: rtl/dvfs_mode_controller_if.sv
// Signal bundle between the DVFS mode controller and its environment
// (workload request, regulator handshake, mode enable and status).
interface dvfs_mode_controller_if;
  logic       perf_req;
  logic       vreg_ack;
  logic       vreg_req_high;
  logic       high_perf_en;
  logic       busy;
  logic       fault;
  logic [2:0] state_o;

  // Controller side
  modport master (
    input  perf_req, vreg_ack,
    output vreg_req_high, high_perf_en, busy, fault, state_o
  );

  // Environment side (workload source and regulator)
  modport slave (
    output perf_req, vreg_ack,
    input  vreg_req_high, high_perf_en, busy, fault, state_o
  );
endinterface

// File: rtl/dvfs_mode_controller.sv
// DVFS mode controller: debounces the workload request and sequences the
// supply so voltage is raised before fast mode is enabled, and fast mode is
// dropped before voltage is lowered. Regulator timeouts pulse fault.
module dvfs_mode_controller #(
  parameter int HYST_CYCLES    = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int DRAIN_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  dvfs_mode_controller_if.master bus
);

  // One timer is shared by all timed states; it is sized for the longest wait.
  localparam int TMAX_SD = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
  localparam int TMAX    = (TMAX_SD > TIMEOUT_CYCLES) ? TMAX_SD : TIMEOUT_CYCLES;
  localparam int TW      = $clog2(TMAX + 1);
  localparam int HW      = $clog2(HYST_CYCLES + 1);

  typedef enum logic [2:0] {
    LOW    = 3'd0,
    VUP    = 3'd1,
    SETTLE = 3'd2,
    HIGH   = 3'd3,
    FDN    = 3'd4,
    VDN    = 3'd5
  } state_t;

  typedef struct packed {
    logic vreg_req_high;
    logic high_perf_en;
    logic busy;
  } outs_t;

  // Output values a state presents from the cycle it is entered.
  function automatic outs_t decode(state_t s);
    outs_t o;
    o.vreg_req_high = (s == VUP) || (s == SETTLE) || (s == HIGH) || (s == FDN);
    o.high_perf_en  = (s == HIGH);
    o.busy          = (s != LOW) && (s != HIGH);
    return o;
  endfunction

  logic          req_f;
  logic [HW-1:0] hyst_cnt;
  state_t        state;
  state_t        nxt;
  outs_t         outs;
  logic          fault_q;
  logic          fault_set;
  logic [TW-1:0] tmr;
  logic          timeout;
  logic          settle_done;
  logic          drain_done;

  assign timeout     = (tmr == TW'(TIMEOUT_CYCLES - 1));
  assign settle_done = (tmr == TW'(SETTLE_CYCLES - 1));
  assign drain_done  = (tmr == TW'(DRAIN_CYCLES - 1));

  // Request filter: req_f follows perf_req only after a sustained mismatch.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks run in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_f    <= 1'b0;
      hyst_cnt <= '0;
    end else if (bus.perf_req == req_f) begin
      hyst_cnt <= '0;
    end else if (hyst_cnt == HW'(HYST_CYCLES - 1)) begin
      req_f    <= bus.perf_req;
      hyst_cnt <= '0;
    end else begin
      hyst_cnt <= hyst_cnt + 1'b1;
    end
  end

  // Next-state decision; timeout is tested first so it wins over a late ack.
  // NOTE: defaults come first so every path assigns nxt and fault_set and no
  // latch is inferred.
  always_comb begin
    nxt       = state;
    fault_set = 1'b0;
    case (state)
      LOW:    if (req_f) nxt = VUP;
      VUP: begin
        if (timeout) begin
          nxt       = VDN;
          fault_set = 1'b1;
        end else if (!req_f) begin
          nxt = VDN;
        end else if (bus.vreg_ack) begin
          nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (!req_f)           nxt = VDN;
        else if (settle_done) nxt = HIGH;
      end
      HIGH:   if (!req_f) nxt = FDN;
      FDN:    if (drain_done) nxt = VDN;
      VDN: begin
        if (timeout)            fault_set = 1'b1;
        else if (!bus.vreg_ack) nxt = LOW;
      end
      default: nxt = LOW;
    endcase
  end

  // State, registered outputs and the shared timer, which reloads on every
  // state entry and on a VDN timeout restart, and saturates otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= LOW;
      outs    <= '0;
      fault_q <= 1'b0;
      tmr     <= '0;
    end else begin
      state   <= nxt;
      outs    <= decode(nxt);
      fault_q <= fault_set;
      if ((nxt != state) || fault_set) begin
        tmr <= '0;
      end else if (tmr != TW'(TMAX)) begin
        tmr <= tmr + 1'b1;
      end
    end
  end

  assign bus.vreg_req_high = outs.vreg_req_high;
  assign bus.high_perf_en  = outs.high_perf_en;
  assign bus.busy          = outs.busy;
  assign bus.fault         = fault_q;
  assign bus.state_o       = state;

endmodule

// File: tb/tb_dvfs_mode_controller.sv
// Self-checking bench for dvfs_mode_controller: a vector table for the
// up/down/glitch flow plus hand sequences for timeout, abort and reset.
module tb_dvfs_mode_controller;

  localparam logic [2:0] S_LOW = 3'd0, S_VUP = 3'd1, S_SETTLE = 3'd2,
                         S_HIGH = 3'd3, S_FDN = 3'd4, S_VDN = 3'd5;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  logic hpe_seen;

  dvfs_mode_controller_if bus ();

  dvfs_mode_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        perf_req;
    logic        vreg_ack;
    int unsigned ticks;
    logic [2:0]  st;
    logic        vrh;
    logic        hpe;
    logic        busy;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_outs(input string name, input logic [2:0] st, input logic vrh,
                            input logic hpe, input logic busy, input logic flt);
    check({name, ".state"}, 32'(bus.state_o), 32'(st));
    check({name, ".vreg_req_high"}, 32'(bus.vreg_req_high), 32'(vrh));
    check({name, ".high_perf_en"}, 32'(bus.high_perf_en), 32'(hpe));
    check({name, ".busy"}, 32'(bus.busy), 32'(busy));
    check({name, ".fault"}, 32'(bus.fault), 32'(flt));
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.high_perf_en === 1'b1) begin
      hpe_seen = 1'b1;
      check("invariant_vrh_with_hpe", 32'(bus.vreg_req_high), 32'd1);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    hpe_seen     = 1'b0;
    reset        = 1'b0;
    bus.perf_req = 1'b1;
    bus.vreg_ack = 1'b1;

    //          req   ack   n  state     vrh   hpe   busy
    vecs[0]  = '{1'b1, 1'b0, 3, S_LOW,    1'b0, 1'b0, 1'b0};  // filter 3/4
    vecs[1]  = '{1'b1, 1'b0, 1, S_LOW,    1'b0, 1'b0, 1'b0};  // req_f rises
    vecs[2]  = '{1'b1, 1'b0, 1, S_VUP,    1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 2, S_VUP,    1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1, S_SETTLE, 1'b1, 1'b0, 1'b1};  // ack seen
    vecs[5]  = '{1'b1, 1'b1, 7, S_SETTLE, 1'b1, 1'b0, 1'b1};  // ack+7
    vecs[6]  = '{1'b1, 1'b1, 1, S_HIGH,   1'b1, 1'b1, 1'b0};  // ack+8
    vecs[7]  = '{1'b0, 1'b1, 4, S_HIGH,   1'b1, 1'b1, 1'b0};  // req_f falls
    vecs[8]  = '{1'b0, 1'b1, 1, S_FDN,    1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1, S_FDN,    1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1, S_VDN,    1'b0, 1'b0, 1'b1};  // 2 after hpe=0
    vecs[11] = '{1'b0, 1'b1, 2, S_VDN,    1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1, S_LOW,    1'b0, 1'b0, 1'b0};  // ack=0
    vecs[13] = '{1'b1, 1'b0, 3, S_LOW,    1'b0, 1'b0, 1'b0};  // 3-cycle glitch
    vecs[14] = '{1'b0, 1'b0, 6, S_LOW,    1'b0, 1'b0, 1'b0};

    // Reset held with active inputs
    ticks(3);
    check_outs("reset_hold", S_LOW, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.perf_req = 1'b0;
    bus.vreg_ack = 1'b0;
    reset        = 1'b1;
    tick();
    check_outs("after_reset", S_LOW, 1'b0, 1'b0, 1'b0, 1'b0);

    // Table: up sequence, down sequence, glitch rejection
    for (int i = 0; i < 15; i++) begin
      bus.perf_req = vecs[i].perf_req;
      bus.vreg_ack = vecs[i].vreg_ack;
      ticks(int'(vecs[i].ticks));
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].vrh, vecs[i].hpe,
                 vecs[i].busy, 1'b0);
    end

    // Timeout in VUP with ack stuck low, then VDN -> LOW, then reset
    hpe_seen     = 1'b0;
    bus.perf_req = 1'b1;
    bus.vreg_ack = 1'b0;
    ticks(5);
    check_outs("to_vup", S_VUP, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("to_wait%0d.fault", i), 32'(bus.fault), 32'd0);
      check($sformatf("to_wait%0d.state", i), 32'(bus.state_o), 32'(S_VUP));
    end
    tick();
    check_outs("to_expire", S_VDN, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check_outs("to_low", S_LOW, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_hpe_never", 32'(hpe_seen), 32'd0);
    reset = 1'b0;
    #1;
    bus.perf_req = 1'b0;
    tick();
    check_outs("to_reset", S_LOW, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // Timeout beats ack arriving at expiry; VDN timeout restarts and re-pulses
    bus.perf_req = 1'b1;
    bus.vreg_ack = 1'b0;
    ticks(5);
    check_outs("pri_vup", S_VUP, 1'b1, 1'b0, 1'b1, 1'b0);
    ticks(15);
    bus.vreg_ack = 1'b1;
    tick();
    check_outs("pri_expire", S_VDN, 1'b0, 1'b0, 1'b1, 1'b1);
    bus.perf_req = 1'b0;
    ticks(15);
    check_outs("vdn_wait", S_VDN, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_outs("vdn_expire", S_VDN, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check_outs("vdn_restart", S_VDN, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.vreg_ack = 1'b0;
    tick();
    check_outs("vdn_low", S_LOW, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort during SETTLE: request falls, VDN without high_perf_en
    hpe_seen     = 1'b0;
    bus.perf_req = 1'b1;
    ticks(5);
    bus.vreg_ack = 1'b1;
    tick();
    check_outs("ab_settle", S_SETTLE, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.perf_req = 1'b0;
    ticks(4);
    check_outs("ab_still", S_SETTLE, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_outs("ab_vdn", S_VDN, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.vreg_ack = 1'b0;
    tick();
    check_outs("ab_low", S_LOW, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ab_hpe_never", 32'(hpe_seen), 32'd0);

    // Reset asserted in HIGH clears outputs without a clock edge
    bus.perf_req = 1'b1;
    ticks(5);
    bus.vreg_ack = 1'b1;
    tick();
    ticks(8);
    check_outs("rh_high", S_HIGH, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_outs("rh_async", S_LOW, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.perf_req = 1'b0;
    bus.vreg_ack = 1'b0;
    tick();
    check_outs("rh_hold", S_LOW, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    ticks(2);
    check_outs("rh_release", S_LOW, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
